// File: rtl/sram_bus_master.sv
// rtl/sram_bus_master.sv - initiator for the three-phase SRAM bus.
// Turns single-cycle CPU read/write requests into registered phase-strobe sequences.
module sram_bus_master #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Req,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic                  Ready,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] RData,
  output logic [ADDR_WIDTH-1:0] AdxBus,
  output logic                  RNW,
  output logic                  OE,
  output logic                  Phase1,
  output logic                  Phase2,
  output logic                  Phase3,
  inout  wire  [DATA_WIDTH-1:0] DataBus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_P1,
    S_GAP1,
    S_P2,
    S_RDOE,
    S_GAP2,
    S_P3
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive;
  logic                    accept;
  logic                    we_next;

  logic                    ready_d;
  logic                    done_d;
  logic                    phase1_d;
  logic                    phase2_d;
  logic                    phase3_d;
  logic                    oe_d;
  logic                    rnw_d;
  logic                    drive_d;

  assign accept  = (state == S_IDLE) && Req;
  assign we_next = accept ? WE : we_q;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (Req) next_state = S_SETUP;
      S_SETUP: next_state = S_P1;
      S_P1:    next_state = S_GAP1;
      S_GAP1:  next_state = S_P2;
      S_P2:    next_state = we_q ? S_GAP2 : S_RDOE;
      S_RDOE:  next_state = S_IDLE;
      S_GAP2:  next_state = S_P3;
      S_P3:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin
  // changes only at the Clock edge and never glitches.
  always_comb begin
    ready_d  = 1'b0;
    done_d   = 1'b0;
    phase1_d = 1'b0;
    phase2_d = 1'b0;
    phase3_d = 1'b0;
    oe_d     = 1'b1;
    rnw_d    = 1'b1;
    drive_d  = 1'b0;
    case (next_state)
      S_IDLE: begin
        ready_d = 1'b1;
        done_d  = (state == S_RDOE) || (state == S_P3);
      end
      S_P1:    phase1_d = 1'b1;
      S_P2:    phase2_d = 1'b1;
      S_P3:    phase3_d = 1'b1;
      S_RDOE:  oe_d     = 1'b0;
      default: ;
    endcase
    if (next_state != S_IDLE) begin
      rnw_d   = !we_next;
      drive_d = we_next;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      AdxBus  <= '0;
      Ready   <= 1'b1;
      Done    <= 1'b0;
      Phase1  <= 1'b0;
      Phase2  <= 1'b0;
      Phase3  <= 1'b0;
      OE      <= 1'b1;
      RNW     <= 1'b1;
      drive   <= 1'b0;
      RData   <= '0;
    end else begin
      state  <= next_state;
      Ready  <= ready_d;
      Done   <= done_d;
      Phase1 <= phase1_d;
      Phase2 <= phase2_d;
      Phase3 <= phase3_d;
      OE     <= oe_d;
      RNW    <= rnw_d;
      drive  <= drive_d;
      if (accept) begin
        we_q    <= WE;
        wdata_q <= WData;
        AdxBus  <= Addr;
      end
      if (state == S_RDOE) RData <= DataBus;
    end
  end

  assign DataBus = drive ? wdata_q : 'z;

  a_no_contention: assert property (@(posedge Clock) disable iff (!nReset)
    !(drive && !OE));
  a_one_strobe: assert property (@(posedge Clock) disable iff (!nReset)
    $onehot0({Phase1, Phase2, Phase3}));
  a_strobe_gap: assert property (@(posedge Clock) disable iff (!nReset)
    (|{Phase1, Phase2, Phase3}) |-> ($past({Phase1, Phase2, Phase3}) == 3'b000));
  a_rnw_write_only: assert property (@(posedge Clock) disable iff (!nReset)
    !RNW |-> drive);

endmodule

// File: tb/tb_sram_bus_master.sv
// tb/tb_sram_bus_master.sv - scoreboard bench for sram_bus_master with a phased SRAM model.
module tb_sram_bus_master;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Req = 1'b0;
  logic          WE = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic [DW-1:0] WData = '0;
  logic          Ready, Done, RNW, OE, Phase1, Phase2, Phase3;
  logic [DW-1:0] RData;
  logic [AW-1:0] AdxBus;
  wire  [DW-1:0] DataBus;

  sram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clock(Clock), .nReset(nReset), .Req(Req), .WE(WE), .Addr(Addr), .WData(WData),
    .Ready(Ready), .Done(Done), .RData(RData), .AdxBus(AdxBus), .RNW(RNW), .OE(OE),
    .Phase1(Phase1), .Phase2(Phase2), .Phase3(Phase3), .DataBus(DataBus)
  );

  always #5 Clock = ~Clock;

  // SRAM slave: latch address on Phase1, data on Phase2, commit on Phase3.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [AW-1:0] sram_adx = '0;
  logic [DW-1:0] sram_dreg = '0;
  always @(posedge Clock) begin
    if (Phase1) sram_adx <= AdxBus;
    if (Phase2) sram_dreg <= DataBus;
    if (Phase3) sram_mem[sram_adx] <= sram_dreg;
  end
  assign DataBus = OE ? 'z : sram_mem[sram_adx];

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          acc;
  } txn_t;

  txn_t          q[$];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rdata = '0;
  logic [AW-1:0] last_addr = '0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            writes_done = 0;
  int            p3_count = 0;

  always @(posedge Clock) cyc <= cyc + 1;
  always @(negedge Clock) if (Phase3) p3_count <= p3_count + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected pin timeline is derived from the offset since acceptance.
  always @(negedge Clock) begin : monitor
    logic [6:0]    exp_v;
    logic [AW-1:0] exp_adx;
    int            off;
    int            lat;
    if (nReset) begin
      exp_v   = 7'b1000011;
      exp_adx = last_addr;
      if (q.size() > 0 && cyc >= q[0].acc) begin
        off     = cyc - q[0].acc;
        lat     = q[0].we ? 6 : 5;
        exp_adx = q[0].addr;
        last_addr = q[0].addr;
        case (off)
          0: exp_v = {2'b00, 3'b000, 1'b1, !q[0].we};
          1: exp_v = {2'b00, 3'b100, 1'b1, !q[0].we};
          2: exp_v = {2'b00, 3'b000, 1'b1, !q[0].we};
          3: exp_v = {2'b00, 3'b010, 1'b1, !q[0].we};
          4: exp_v = q[0].we ? 7'b0000010 : 7'b0000001;
          5: exp_v = q[0].we ? 7'b0000110 : 7'b1100011;
          default: exp_v = 7'b1100011;
        endcase
        if (q[0].we && off < lat) check("databus_drive", DataBus, q[0].data);
        if (off >= lat) begin
          check("done_latency", off, lat);
          if (q[0].we) begin
            exp_mem[q[0].addr] = q[0].data;
            writes_done++;
          end else begin
            last_rdata = exp_mem[q[0].addr];
          end
          void'(q.pop_front());
        end
      end
      check("pins{rdy,done,p1,p2,p3,oe,rnw}", {Ready, Done, Phase1, Phase2, Phase3, OE, RNW}, exp_v);
      check("adxbus", AdxBus, exp_adx);
      check("rdata", RData, last_rdata);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!Ready && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (!Ready) check("ready_timeout", Ready, 1);
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    txn_t t;
    wait_ready();
    Req = 1'b1; WE = we; Addr = a; WData = d;
    t.we = we; t.addr = a; t.data = d; t.acc = cyc + 1;
    q.push_back(t);
    @(negedge Clock);
    if (!hold) Req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge Clock);
      #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_pins"}, {Ready, Done, Phase1, Phase2, Phase3, OE, RNW}, 7'b1000011);
    check({tag, "_rdata"}, RData, 0);
    check({tag, "_adx"}, AdxBus, 0);
  endtask

  initial begin
    bit          we, drain_after;
    logic [AW-1:0] a;
    logic [DW-1:0] pool [4];
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = '0;
      exp_mem[i]  = '0;
    end
    pool[0] = 11'h005; pool[1] = 11'h010; pool[2] = 11'h3FF; pool[3] = 11'h001;

    repeat (3) @(negedge Clock);
    check_reset_pins("reset");
    #2 nReset = 1'b1;
    @(negedge Clock);

    issue(1, 11'h005, 32'hDEADBEEF, 0);
    issue(0, 11'h005, 32'h0, 0);
    drain();

    issue(1, 11'h3FF, 32'h11111111, 0);
    issue(1, 11'h001, 32'h22222222, 0);
    issue(0, 11'h3FF, 32'h0, 0);
    issue(0, 11'h001, 32'h0, 0);
    drain();

    issue(1, 11'h020, 32'hA5A5A5A5, 1);
    issue(0, 11'h020, 32'h0, 1);
    issue(1, 11'h021, 32'h5A5A5A5A, 1);
    issue(0, 11'h021, 32'h0, 1);
    issue(1, 11'h022, 32'h01234567, 1);
    issue(0, 11'h022, 32'h0, 0);
    drain();

    issue(0, 11'h005, 32'h0, 0);
    Req = 1'b1; WE = 1'b1; Addr = 11'h005; WData = 32'h55555555;
    @(negedge Clock);
    Req = 1'b0;
    drain();
    issue(0, 11'h005, 32'h0, 0);
    drain();

    issue(1, 11'h010, 32'hCAFEF00D, 0);
    drain();
    issue(1, 11'h010, 32'h0BADBEEF, 0);
    repeat (4) @(negedge Clock);
    #2 nReset = 1'b0;
    q.delete();
    last_rdata = '0;
    last_addr  = '0;
    #1 check_reset_pins("abort");
    repeat (3) begin
      @(negedge Clock);
      check("abort_phase3", Phase3, 0);
    end
    #2 nReset = 1'b1;
    @(negedge Clock);
    issue(0, 11'h010, 32'h0, 0);
    drain();

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, (1 << AW) - 1)) : pool[$urandom_range(0, 3)][AW-1:0];
      drain_after = ($urandom_range(0, 2) == 0) || (i == 39);
      issue(we, a, $urandom, !drain_after);
      if (drain_after) begin
        drain();
        repeat ($urandom_range(0, 3)) @(negedge Clock);
      end
    end
    drain();

    check("phase3_count", p3_count, writes_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_bus_master.md
Name: sram_bus_master

Overview:
- Initiator for the three-phase SRAM bus (DataBus/AdxBus/OE/RNW plus three phase strobes).
- Converts single-clock CPU-side read/write requests into the phased bus sequence.
- Generates the phase strobes as registered single-cycle pulses.
- Captures read data, then returns a one-cycle Done pulse.
- Sits between the datapath's memory stage and the SRAM array.

Parameters:
- ADDR_WIDTH, 11: width of Addr/AdxBus.
- DATA_WIDTH, 32: width of WData/RData/DataBus.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- nReset  input  1  asynchronous active-low reset.
- Req  input  1  request strobe; sampled only when Ready=1.
- WE  input  1  1=write, 0=read; sampled with Req.
- Addr  input  ADDR_WIDTH  word address; sampled with Req.
- WData  input  DATA_WIDTH  write data; sampled with Req.
- Ready  output  1  1 when idle and able to accept Req.
- Done  output  1  one-cycle pulse at transaction completion.
- RData  output  DATA_WIDTH  read result; valid from the Done cycle until the next read completes.
- AdxBus  output  ADDR_WIDTH  SRAM address; passed unmodified.
- RNW  output  1  1=read/idle, 0=write.
- OE  output  1  active-low SRAM output enable (0 = SRAM drives DataBus).
- Phase1  output  1  address-latch strobe.
- Phase2  output  1  data-register strobe.
- Phase3  output  1  write-commit strobe.
- DataBus  inout  DATA_WIDTH  shared bidirectional data bus.

Behaviour:
- Interface decision: one clock (Clock); asynchronous, active-low reset (nReset).
- Reset: state=IDLE; Ready=1, Done=0, RData=0, AdxBus=0, RNW=1, OE=1, Phase1/2/3=0; DataBus released (Z).
  - nReset asserted mid-transaction aborts immediately; no further strobes are issued.
- All outputs are registered, so strobe edges are glitch-free and coincide with Clock posedge.
- Acceptance: at a posedge with state=IDLE and Req=1, latch Addr, WE, WData; leave IDLE.
  - Req while Ready=0 is ignored and not queued.
- States and per-state outputs (unlisted outputs hold idle values):
  - IDLE: Ready=1.
  - SETUP: AdxBus=addr_q; RNW=!we_q; all strobes 0.
  - P1: Phase1=1.
  - GAP1: all strobes 0.
  - P2: Phase2=1.
  - Read path: P2 -> RDOE. In RDOE, OE=0; RData captured from DataBus at the end of RDOE; then -> IDLE with Done=1.
  - Write path: P2 -> GAP2 -> P3 (Phase3=1) -> IDLE with Done=1.
- Transitions are unconditional after acceptance: SETUP->P1->GAP1->P2, then the read or write path above.
- Latency, with acceptance at edge E0:
  - Read: Done high in cycle E5–E6.
  - Write: Done high in cycle E6–E7.
- Done cycle: state is already IDLE (Ready=1), so a new Req in that cycle is accepted. Back-to-back throughput is one transaction per 6 cycles (read) or 7 cycles (write).
- RNW: held low from SETUP through P3 on writes; returns to 1 in IDLE.
- AdxBus holds its last value while idle.
- DataBus drive rule:
  - The master drives WData_q only in write-path states SETUP..P3; otherwise Z.
  - OE=0 only in RDOE, which occurs only on reads.
  - Master drive and OE=0 are therefore never simultaneous; checked by an assertion.
- At most one Phase strobe is high in any cycle; each strobe is preceded by a cycle with all strobes low.
- Abort safety: reset before P3 guarantees no memory write (Phase3 never rises).

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x005, then read 0x005 -> Done 6 cycles after write accept; read Done 5 cycles after read accept; RData=0xDEADBEEF.
- Write 0x11111111 to 0x3FF, then write 0x22222222 to 0x001; read both -> 0x11111111 and 0x22222222; AdxBus matches each Addr during SETUP..P2/P3.
- Req held high continuously with alternating WE -> new transaction accepted in every Done cycle; no Req lost or duplicated; Ready=0 throughout each transaction.
- Req pulsed in P1 of an active read -> ignored; exactly one Done; RData unchanged by the ignored request.
- Write 0xCAFEF00D to 0x010, then start write 0x0BADBEEF to 0x010 and assert nReset during GAP2 -> outputs reach reset values asynchronously; Phase3 never pulses; subsequent read of 0x010 returns 0xCAFEF00D.
- Continuous assertions across all tests:
  - Never (master driving && OE==0).
  - At most one Phase strobe high per cycle.
  - RNW==0 only between SETUP and P3 of a write.
